// File: rtl/surf_trig_gen_v4.sv
// surf_trig_gen_v4: masked beam OR-reduce, holdoff FSM, address stamp,
// FWFT trigger-word FIFO to AXI4-Stream, accepted/overflow counters.
//
// Ports:
//   ifclk, gen_rstn_i          clock, async active-low reset
//   trig_i, mask_i, mask_wr_i  beam triggers and mask load
//   holdoff_i                  min trigger spacing minus 1
//   offset_i, runrst_i,        run control and address offset
//   runstop_i
//   trig_tdata/tvalid/tready   AXI4-Stream trigger word out
//   trig_count_o, ovf_count_o  accepted / dropped word counters
module surf_trig_gen_v4 #(
  parameter int NBEAMS     = 48,
  parameter int FIFO_DEPTH = 16,
  parameter int HOLDOFF_W  = 8
) (
  input  logic                 ifclk,
  input  logic                 gen_rstn_i,
  input  logic [NBEAMS-1:0]    trig_i,
  input  logic [NBEAMS-1:0]    mask_i,
  input  logic                 mask_wr_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic [11:0]          offset_i,
  input  logic                 runrst_i,
  input  logic                 runstop_i,
  output logic [31:0]          trig_tdata,
  output logic                 trig_tvalid,
  input  logic                 trig_tready,
  output logic [15:0]          trig_count_o,
  output logic [15:0]          ovf_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic {IDLE, HOLD} state_e;

  logic [NBEAMS-1:0]    mask_q;
  logic [NBEAMS-1:0]    beams_q;
  logic                 hit_q;
  logic [7:0]           meta_q;
  logic [7:0]           meta_d;
  logic                 running_q;
  logic [11:0]          addr_q;
  logic [11:0]          offset_q;
  state_e               state_q;
  logic [HOLDOFF_W-1:0] cnt_q;
  logic [31:0]          word_q;
  logic                 wr_q;
  logic [15:0]          trig_cnt_q;
  logic [15:0]          ovf_q;
  logic [31:0]          mem [FIFO_DEPTH];
  logic [AW:0]          wp_q;
  logic [AW:0]          rp_q;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic accept;
  logic multi;
  logic [6:0] idx;

  // Lowest set beam wins; x & (x-1) is nonzero iff two or more bits set.
  always_comb begin
    idx = '0;
    for (int i = NBEAMS - 1; i >= 0; i--) begin
      if (beams_q[i]) idx = 7'(i);
    end
    multi  = |(beams_q & (beams_q - NBEAMS'(1)));
    meta_d = (|beams_q) ? {multi, idx} : 8'h00;
  end

  always_ff @(posedge ifclk or negedge gen_rstn_i) begin
    if (!gen_rstn_i) begin
      mask_q  <= '1;
      beams_q <= '0;
      hit_q   <= 1'b0;
      meta_q  <= 8'h00;
    end else begin
      if (mask_wr_i) mask_q <= mask_i;
      beams_q <= trig_i & ~mask_q;
      hit_q   <= |beams_q;
      meta_q  <= meta_d;
    end
  end

  always_ff @(posedge ifclk or negedge gen_rstn_i) begin
    if (!gen_rstn_i) begin
      running_q <= 1'b0;
      offset_q  <= 12'h000;
      addr_q    <= 12'h001;
    end else begin
      if (runrst_i) begin
        running_q <= 1'b1;
        offset_q  <= offset_i;
      end else if (runstop_i) begin
        running_q <= 1'b0;
      end
      addr_q <= (running_q && !runrst_i) ? addr_q + 12'd1 : 12'd1;
    end
  end

  assign accept = hit_q && running_q && (state_q == IDLE);

  always_ff @(posedge ifclk or negedge gen_rstn_i) begin
    if (!gen_rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      wr_q <= accept;
      if (accept) begin
        cnt_q   <= holdoff_i;
        state_q <= (holdoff_i == '0) ? IDLE : HOLD;
        word_q  <= {2'b10, addr_q + offset_q, 2'b00, 8'h00, meta_q};
      end else if (state_q == HOLD) begin
        cnt_q <= cnt_q - HOLDOFF_W'(1);
        if (cnt_q == HOLDOFF_W'(1)) state_q <= IDLE;
      end
    end
  end

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = !empty && trig_tready;
  // A pop in the same cycle frees the slot for a write to a full FIFO.
  assign push  = wr_q && (!full || pop);
  assign drop  = wr_q && full && !pop;

  always_ff @(posedge ifclk or negedge gen_rstn_i) begin
    if (!gen_rstn_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (pop)  rp_q <= rp_q + PTR_ONE;
    end
  end

  always_ff @(posedge ifclk) begin
    if (push) mem[wp_q[AW-1:0]] <= word_q;
  end

  always_ff @(posedge ifclk or negedge gen_rstn_i) begin
    if (!gen_rstn_i) begin
      trig_cnt_q <= 16'h0;
      ovf_q      <= 16'h0;
    end else begin
      if (runrst_i) begin
        trig_cnt_q <= 16'h0;
        ovf_q      <= 16'h0;
      end else begin
        if (accept) trig_cnt_q <= trig_cnt_q + 16'd1;
        if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  assign trig_tvalid  = !empty;
  assign trig_tdata   = empty ? 32'h0 : mem[rp_q[AW-1:0]];
  assign trig_count_o = trig_cnt_q;
  assign ovf_count_o  = ovf_q;

endmodule

// File: tb/tb_surf_trig_gen_v4.sv
// tb_surf_trig_gen_v4: directed bench for surf_trig_gen_v4
// with hand-computed expected trigger words and counters.
module tb_surf_trig_gen_v4;

  logic        ifclk = 1'b0;
  logic        rstn;
  logic [47:0] trig;
  logic [47:0] mask;
  logic        mask_wr;
  logic [7:0]  holdoff;
  logic [11:0] offset;
  logic        runrst;
  logic        runstop;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [15:0] tcnt;
  logic [15:0] ovf;

  int n_chk  = 0;
  int n_fail = 0;

  int          nw;
  int          cyc [8];
  logic [31:0] w   [8];
  logic [7:0]  last_meta;

  surf_trig_gen_v4 #(
    .NBEAMS(48),
    .FIFO_DEPTH(4),
    .HOLDOFF_W(8)
  ) dut (
    .ifclk(ifclk),
    .gen_rstn_i(rstn),
    .trig_i(trig),
    .mask_i(mask),
    .mask_wr_i(mask_wr),
    .holdoff_i(holdoff),
    .offset_i(offset),
    .runrst_i(runrst),
    .runstop_i(runstop),
    .trig_tdata(tdata),
    .trig_tvalid(tvalid),
    .trig_tready(tready),
    .trig_count_o(tcnt),
    .ovf_count_o(ovf)
  );

  always #5 ifclk = ~ifclk;

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    trig    = '0;
    mask    = '0;
    mask_wr = 1'b0;
    holdoff = 8'd0;
    offset  = 12'h000;
    runrst  = 1'b0;
    runstop = 1'b0;
    tready  = 1'b0;
    #12;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tcnt", 32'(tcnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Basic trigger: hit_q cycle sees address 3, +0x010 -> 0x013.
    mask_wr = 1'b1;
    mask    = '0;
    tick();
    mask_wr = 1'b0;
    offset  = 12'h010;
    runrst  = 1'b1;
    tick();
    runrst  = 1'b0;
    trig    = 48'h1 << 5;
    tick();
    trig    = '0;
    tick();
    tick();
    chk("basic_tvalid_e2", 32'(tvalid), 32'd0);
    chk("basic_tcnt", 32'(tcnt), 32'd1);
    tick();
    chk("basic_tvalid_e3", 32'(tvalid), 32'd1);
    chk("basic_word", tdata, 32'h804C0005);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("basic_drained", 32'(tvalid), 32'd0);

    // Holdoff 7, beams 3 and 40 high for 40 cycles.
    holdoff = 8'd7;
    tready  = 1'b1;
    trig    = (48'h1 << 3) | (48'h1 << 40);
    nw      = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 40) trig = '0;
      tick();
      if (tvalid && nw < 8) begin
        cyc[nw] = c;
        w[nw]   = tdata;
        nw++;
      end
    end
    tready  = 1'b0;
    holdoff = 8'd0;
    chk("hold_nwords", 32'(nw), 32'd5);
    for (int i = 0; i < nw && i < 8; i++) begin
      chk("hold_meta", 32'(w[i][7:0]), 32'h83);
    end
    for (int i = 1; i < nw && i < 8; i++) begin
      chk("hold_spacing", 32'(cyc[i] - cyc[i-1]), 32'd8);
      chk("hold_addr_step",
          32'(w[i][29:18] - w[i-1][29:18]), 32'd8);
    end
    chk("hold_tcnt", 32'(tcnt), 32'd6);

    // Mask beam 3: alone it produces nothing.
    mask    = 48'h1 << 3;
    mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
    trig    = 48'h1 << 3;
    tick();
    trig    = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("mask_no_word", 32'(tvalid), 32'd0);
    trig = (48'h1 << 3) | (48'h1 << 9);
    tick();
    trig = '0;
    tick();
    tick();
    tick();
    chk("mask_word_valid", 32'(tvalid), 32'd1);
    chk("mask_meta", 32'(tdata[7:0]), 32'h09);
    chk("mask_tcnt", 32'(tcnt), 32'd7);
    tready = 1'b1;
    tick();
    tready = 1'b0;

    // Overflow: 10 back-to-back hits into a 4-deep FIFO.
    offset = 12'h000;
    runrst = 1'b1;
    tick();
    runrst = 1'b0;
    chk("ovf_tcnt_cleared", 32'(tcnt), 32'd0);
    trig = 48'h1;
    for (int i = 0; i < 10; i++) tick();
    trig = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("ovf_count", 32'(ovf), 32'd6);
    chk("ovf_tcnt", 32'(tcnt), 32'd10);
    chk("ovf_tvalid", 32'(tvalid), 32'd1);
    trig = 48'h1 << 1;
    tick();
    trig = '0;
    tick();
    tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("ovf_pop_write_ovf", 32'(ovf), 32'd6);
    chk("ovf_pop_write_tcnt", 32'(tcnt), 32'd11);
    tready    = 1'b1;
    nw        = 0;
    last_meta = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (tvalid) begin
        nw++;
        last_meta = tdata[7:0];
      end
      tick();
    end
    tready = 1'b0;
    chk("ovf_drain_n", 32'(nw), 32'd4);
    chk("ovf_drain_last", 32'(last_meta), 32'h01);
    chk("ovf_drained", 32'(tvalid), 32'd0);

    // Address wrap: hit at address 2 with offset 0xFFF -> 0x001.
    mask    = '0;
    mask_wr = 1'b1;
    offset  = 12'hFFF;
    runrst  = 1'b1;
    trig    = 48'h1 << 2;
    tick();
    mask_wr = 1'b0;
    runrst  = 1'b0;
    trig    = '0;
    chk("wrap_ovf_cleared", 32'(ovf), 32'd0);
    chk("wrap_tcnt_cleared", 32'(tcnt), 32'd0);
    tick();
    tick();
    chk("wrap_not_yet", 32'(tvalid), 32'd0);
    tick();
    chk("wrap_valid", 32'(tvalid), 32'd1);
    chk("wrap_word", tdata, 32'h80040002);

    // Async reset mid-transfer with a word pending.
    tready = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_tvalid", 32'(tvalid), 32'd0);
    chk("arst_tdata", tdata, 32'h0);
    chk("arst_tcnt", 32'(tcnt), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    tready = 1'b0;
    tick();
    rstn   = 1'b1;
    tick();
    runrst = 1'b1;
    tick();
    runrst = 1'b0;
    trig   = '1;
    for (int i = 0; i < 3; i++) tick();
    trig = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("arst_masked", 32'(tvalid), 32'd0);
    chk("arst_masked_tcnt", 32'(tcnt), 32'd0);
    mask    = '0;
    mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
    trig    = 48'h1 << 7;
    tick();
    trig = '0;
    tick();
    tick();
    tick();
    chk("arst_unmask_valid", 32'(tvalid), 32'd1);
    chk("arst_unmask_meta", 32'(tdata[7:0]), 32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/surf_trig_gen_v4.md
# surf_trig_gen_v4

Parametrised next-generation SURF trigger generator, fully in the ifclk domain. It masks and OR-reduces up to 128 beam triggers and enforces a runtime-programmable holdoff. Each accepted trigger is stamped with a run-relative address and first-beam/multi-beam metadata. Trigger words are buffered in a parametrised FWFT FIFO that drives the 32-bit AXI4-Stream trigger output to the TURF, with overflow and accepted-trigger counters.

## Interface
Parameters:
- NBEAMS, 48, number of beam inputs; legal range 1..128.
- FIFO_DEPTH, 16, trigger-word FIFO entries; power of 2, legal range 4..64.
- HOLDOFF_W, 8, width of the holdoff register.

Ports:
- ifclk  in  1  sole clock.
- gen_rstn_i  in  1  reset. Asynchronous assert, active-low, deasserted synchronously to ifclk upstream.
- trig_i  in  NBEAMS  beam triggers, already in the ifclk domain, 1 = fired.
- mask_i  in  NBEAMS  beam mask, 1 = beam disabled.
- mask_wr_i  in  1  loads mask_i into the mask register.
- holdoff_i  in  HOLDOFF_W  minimum trigger spacing minus 1, in ifclk cycles; sampled at each accept.
- offset_i  in  12  address offset; captured on runrst_i.
- runrst_i  in  1  starts a run.
- runstop_i  in  1  stops a run.
- trig_tdata  out  32  trigger word.
- trig_tvalid  out  1  trigger word valid.
- trig_tready  in  1  downstream ready.
- trig_count_o  out  16  accepted triggers this run; wraps.
- ovf_count_o  out  16  trigger words dropped because the FIFO was full; saturates at 0xFFFF.

## Operation
- **Reset values:** mask_q = all ones, so no triggers pass. running = 0, current_address = 1, offset_q = 0, holdoff counter = 0, state IDLE. FIFO empty, trig_tvalid = 0, trig_tdata = 0, both counters = 0.
- **Mask:** mask_wr_i=1 at an edge loads mask_q <= mask_i. The new mask affects trig_i sampled at the following edge.
- **Stage 1:** beams_q <= trig_i & ~mask_q.
- **Stage 2 (hit_q):** hit_q <= |beams_q.
- **Stage 2 (meta_q):** meta_q <= {multi, first_idx[6:0]}.
  - first_idx is the lowest set bit index of beams_q.
  - multi = 1 when more than one bit of beams_q is set.
  - meta_q = 0 when no bit is set.
- **Run control:**
  - runrst_i sets running, captures offset_q <= offset_i, and clears trig_count_o and ovf_count_o.
  - runstop_i clears running.
  - runrst_i wins if both are asserted.
- **Address:** when not running, current_address <= 1. When running, it increments by 1 per cycle and wraps modulo 4096.
- **Holdoff FSM states:** IDLE (counter == 0) and HOLD (counter != 0).
- **Accept condition:** accept = hit_q && running && IDLE. On accept:
  - counter <= holdoff_i.
  - word_q <= {2'b10, (current_address + offset_q) mod 4096, 2'b00, 8'h00, meta_q}.
  - wr_q <= 1.
  - trig_count_o increments.
- **HOLD:** the counter decrements by 1 per cycle. hit_q in HOLD is discarded and does not extend the holdoff.
- **holdoff_i = 0:** accepts are possible every cycle.
- **runstop_i mid-holdoff:** the counter keeps running down.
- **FIFO:** FWFT. trig_tvalid = !empty and trig_tdata = head word. A pop occurs when trig_tvalid && trig_tready.
- **FIFO full:** a write to a full FIFO is dropped and ovf_count_o increments, unless a pop occurs in the same cycle; in that case the write is accepted.
- **Counters vs reset:** runrst_i does not flush the FIFO. Only gen_rstn_i clears the FIFO, asynchronously, mid-transfer included.

## Timing
- **Input to tvalid:** trig_i asserted before edge 0 gives beams_q at edge 0, hit_q at edge 1, word_q/wr_q at edge 2, FIFO write at edge 3. trig_tvalid is high after edge 3 if the FIFO was empty, i.e. 4 edges from trig_i sampling.
- **Captured address:** the current_address value held during the cycle hit_q = 1.
- **Accept spacing:** accepted triggers are at least holdoff_i+1 cycles apart. With constant hit_q = 1, an accept occurs every holdoff_i+1 cycles.
- **Handshake rules:**
  - trig_tdata holds stable while trig_tvalid && !trig_tready.
  - trig_tvalid never deasserts without a pop, except on reset.
- **Run start:** runrst_i at edge n gives current_address = 1 after edge n and 2 after edge n+1.

## Test plan
- **Basic trigger:** mask all zeros, offset_i=0x010, runrst_i, then trig_i bit 5 for one cycle -> one word 0b10_addr_00_0x00_0x05 with addr = current_address in the hit_q cycle + 0x010. trig_tvalid rises 4 edges after trig_i; trig_count_o=1.
- **Holdoff and metadata:** holdoff_i=7, trig_i bits 3 and 40 held high for 40 cycles -> exactly 5 words, spaced 8 cycles apart, each with meta = 0x83.
- **Mask:** mask_i bit 3 set via mask_wr_i, then trig_i = bit 3 only -> no word. Then trig_i = bits 3 and 9 -> meta = 0x09.
- **Overflow:** FIFO_DEPTH=4, holdoff_i=0, trig_tready=0, 10 hits -> 4 words held, ovf_count_o=6. Hit with tready=1 while full -> accepted, ovf unchanged.
- **Address wrap:** offset_i=0xFFF, hit at current_address=2 -> address field 0x001.
- **Async reset:** gen_rstn_i low mid-transfer with FIFO non-empty -> trig_tvalid=0 immediately, counters 0, mask all ones. After release, hits produce no words until mask_wr_i and runrst_i.
